mips_state_dump: RTL and testbench

Debug read-out engine for the pipelined MIPS32 core. On a start pulse it halts the core and walks the architectural state: optionally all general registers, then a window of data memory. Every word goes out on a valid/ready stream tagged with its source and index. It is the read-side counterpart of the bench/loader path that writes ProgMem and Reg. Benches and the debug UART bridge use it to check results without hierarchical peeking.

---
 rtl/mips_state_dump.sv | 177 +++++++++++++++++
 tb/tb_mips_state_dump.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_state_dump.sv
// mips_state_dump
//
// Debug read-out engine for the pipelined MIPS32 core. A start pulse halts
// the core and streams its architectural state out on a valid/ready port:
// optionally every general register, then a window of data memory. Each
// word carries a source tag and its register number or memory address.
//
// Ports:
//   clk           core clock, rising edge
//   reset         asynchronous, active-low
//   start         one-cycle dump request, sampled only while idle
//   include_regs  sampled with start; 1 = dump registers before memory
//   base_addr     first data memory word, sampled with start
//   count         data memory words to dump (0..DMEM_DEPTH), sampled with start
//   halt_req      core freeze request, registered copy of busy
//   rf_addr       register file read address
//   rf_rdata      register file data, combinational from rf_addr
//   dm_rd_en      data memory read strobe
//   dm_addr       data memory read address
//   dm_rdata      data memory data, valid one cycle after dm_rd_en
//   out_valid     stream word valid
//   out_ready     consumer accepts word
//   out_data      dumped word
//   out_tag       0 = register, 1 = data memory
//   out_index     register number or (wrapped) memory address
//   out_last      final word of this dump
//   busy          dump in progress
//   done          one-cycle pulse on the edge after the final word is accepted
module mips_state_dump #(
    parameter int NREG       = 32,
    parameter int DMEM_DEPTH = 1024,
    parameter int AW         = 10,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          include_regs,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic          halt_req,
    output logic [4:0]    rf_addr,
    input  logic [DW-1:0] rf_rdata,
    output logic          dm_rd_en,
    output logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_tag,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        REGS,
        MEM_REQ,
        MEM_WAIT,
        FLUSH
    } state_t;

    state_t        state;
    logic [4:0]    reg_idx;
    logic [AW:0]   mem_i;
    logic [AW:0]   cnt_r;
    logic [AW-1:0] base_r;

    logic          can_load;
    logic          last_reg;
    logic          last_mem;
    logic [AW:0]   addr_sum;

    // The output register may take a new word when empty or when its
    // current word is being accepted on this same edge.
    assign can_load = !out_valid || out_ready;

    assign last_reg = (reg_idx == 5'(NREG - 1));
    assign last_mem = (mem_i == cnt_r - (AW + 1)'(1));

    // DMEM_DEPTH is a power of two, so the modulo reduces to truncation.
    assign addr_sum = {1'b0, base_r} + mem_i;
    assign dm_addr  = AW'(addr_sum % (AW + 1)'(DMEM_DEPTH));

    assign rf_addr  = reg_idx;

    // A read is only issued when the returning word is guaranteed a free
    // output register on the following edge, so MEM_WAIT never stalls.
    assign dm_rd_en = (state == MEM_REQ) && can_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            reg_idx   <= '0;
            mem_i     <= '0;
            cnt_r     <= '0;
            base_r    <= '0;
            halt_req  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        cnt_r    <= count;
                        reg_idx  <= '0;
                        mem_i    <= '0;
                        busy     <= 1'b1;
                        halt_req <= 1'b1;
                        if (include_regs) begin
                            state <= REGS;
                        end else if (count != '0) begin
                            state <= MEM_REQ;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end

                REGS: begin
                    if (can_load) begin
                        out_valid <= 1'b1;
                        out_data  <= rf_rdata;
                        out_tag   <= 1'b0;
                        out_index <= AW'(reg_idx);
                        out_last  <= last_reg && (cnt_r == '0);
                        reg_idx   <= reg_idx + 5'd1;
                        if (last_reg) begin
                            state <= (cnt_r != '0) ? MEM_REQ : FLUSH;
                        end
                    end
                end

                MEM_REQ: begin
                    if (can_load) begin
                        state <= MEM_WAIT;
                    end
                end

                MEM_WAIT: begin
                    out_valid <= 1'b1;
                    out_data  <= dm_rdata;
                    out_tag   <= 1'b1;
                    out_index <= dm_addr;
                    out_last  <= last_mem;
                    mem_i     <= mem_i + (AW + 1)'(1);
                    state     <= last_mem ? FLUSH : MEM_REQ;
                end

                FLUSH: begin
                    if (!out_valid) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        halt_req <= 1'b0;
                        done     <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_state_dump.sv
// Self-checking bench for mips_state_dump: register file and data memory
// models, a queue of expected stream words built from the dump rules, and a
// negedge monitor that checks handshakes, stalls, busy and done.
module tb_mips_state_dump;

    localparam int NREG  = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          include_regs = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          halt_req;
    logic [4:0]    rf_addr;
    logic [DW-1:0] rf_rdata;
    logic          dm_rd_en;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_tag;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    mips_state_dump #(
        .NREG      (NREG),
        .DMEM_DEPTH(DEPTH),
        .AW        (AW),
        .DW        (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .include_regs(include_regs),
        .base_addr   (base_addr),
        .count       (count),
        .halt_req    (halt_req),
        .rf_addr     (rf_addr),
        .rf_rdata    (rf_rdata),
        .dm_rd_en    (dm_rd_en),
        .dm_addr     (dm_addr),
        .dm_rdata    (dm_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] dmem [DEPTH];

    assign rf_rdata = regs[rf_addr];
    always @(posedge clk) if (dm_rd_en) dm_rdata <= dmem[dm_addr];

    typedef struct {
        logic          tag;
        int            idx;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t expq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit exp_busy = 1'b0;
    int busy_cycles, rd_count, done_count, hs_count;
    int last_hs_cyc, first_valid_cyc, done_cyc;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_tag, prev_last;
    logic [AW-1:0] prev_index;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Edges from the sampling edge E0 to the done edge with out_ready held high.
    function automatic int full_rate_cycles(input bit incl, input int n);
        if (incl) return NREG + 2 + 2 * n;
        if (n == 0) return 1;
        return 2 * n + 2;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                done_count++;
                check("done_only_when_busy", 64'(exp_busy), 64'd1);
                check("done_queue_drained", 64'(expq.size()), 64'd0);
                if (hs_count > 0) check("done_latency", 64'(cyc - last_hs_cyc), 64'd2);
                done_cyc = cyc;
                exp_busy = 1'b0;
            end
            check("busy", 64'(busy), 64'(exp_busy));
            check("halt_req", 64'(halt_req), 64'(exp_busy));
            if (busy) busy_cycles++;
            if (dm_rd_en) rd_count++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_tag", 64'(out_tag), 64'(prev_tag));
                check("stall_index", 64'(out_index), 64'(prev_index));
                check("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_word", 64'(out_valid), 64'd0);
                end else begin
                    word_t w;
                    w = expq.pop_front();
                    check("word_tag", 64'(out_tag), 64'(w.tag));
                    check("word_index", 64'(out_index), 64'(w.idx));
                    check("word_data", 64'(out_data), 64'(w.data));
                    check("word_last", 64'(out_last), 64'(w.last));
                end
                hs_count++;
                last_hs_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
            prev_index = out_index;
            prev_last  = out_last;
        end
    end

    task automatic run_dump(input bit incl, input int base, input int n, input int pct,
                            input bit double_start);
        int words;
        int e0;
        expq.delete();
        if (incl) begin
            for (int k = 0; k < NREG; k++) begin
                expq.push_back('{1'b0, k, regs[k], (k == NREG - 1) && (n == 0)});
            end
        end
        for (int j = 0; j < n; j++) begin
            int a;
            a = (base + j) % DEPTH;
            expq.push_back('{1'b1, a, dmem[a], j == n - 1});
        end
        words = expq.size();
        busy_cycles = 0; rd_count = 0; done_count = 0; hs_count = 0;
        first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1; prev_stall = 1'b0;

        @(posedge clk); #1;
        start        = 1'b1;
        include_regs = incl;
        base_addr    = AW'(base);
        count        = (AW + 1)'(n);
        out_ready    = (int'($urandom_range(99)) < pct);
        @(posedge clk); #1;
        e0       = cyc;
        exp_busy = 1'b1;
        start    = double_start;
        // Scramble the request inputs: they must not be re-sampled mid-dump.
        include_regs = 1'($urandom);
        base_addr    = AW'($urandom);
        count        = (AW + 1)'($urandom);
        for (int k = 0; k < 5000 && done_cyc < 0; k++) begin
            out_ready = (int'($urandom_range(99)) < pct);
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("dump_finished", 64'(done_cyc >= 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 64'(expq.size()), 64'd0);
        check("words_accepted", 64'(hs_count), 64'(words));
        check("dm_reads", 64'(rd_count), 64'(n));
        check("done_pulses", 64'(done_count), 64'd1);
        if (words > 0) check("first_latency", 64'(first_valid_cyc - e0), incl ? 64'd1 : 64'd2);
        if (words == 0) check("empty_busy_cycles", 64'(busy_cycles), 64'd1);
        if (pct >= 100) check("dump_cycles", 64'(done_cyc - e0), 64'(full_rate_cycles(incl, n)));
    endtask

    initial begin
        bit found;
        for (int k = 0; k < NREG; k++) regs[k] = DW'(k);
        for (int a = 0; a < DEPTH; a++) dmem[a] = $urandom;

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_halt_req", 64'(halt_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_dm_rd_en", 64'(dm_rd_en), 64'd0);
        check("rst_dm_addr", 64'(dm_addr), 64'd0);
        check("rst_rf_addr", 64'(rf_addr), 64'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Registers only, Reg[k]=k
        run_dump(1'b1, 0, 0, 100, 1'b0);

        // Single memory word
        dmem[11] = 32'd12;
        run_dump(1'b0, 11, 1, 100, 1'b0);

        // Backpressure over registers + memory, with a second start mid-dump
        for (int k = 0; k < NREG; k++) regs[k] = $urandom;
        run_dump(1'b1, int'($urandom_range(DEPTH - 1)), 8, 30, 1'b1);

        // Address wrap
        for (int a = 0; a < DEPTH; a++) dmem[a] = DW'(a + 100);
        run_dump(1'b0, 1022, 4, 100, 1'b0);
        run_dump(1'b0, 1022, 4, 50, 1'b0);

        // Empty dump with start held into the busy cycle
        run_dump(1'b0, 5, 0, 100, 1'b1);

        // Reset while register 5 is on the output
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; include_regs = 1'b1; base_addr = '0; count = (AW + 1)'(3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_index == AW'(5)) found = 1'b1;
        end
        check("reached_reg5", 64'(found), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_halt_req", 64'(halt_req), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_index", 64'(out_index), 64'd0);
        check("abort_rf_addr", 64'(rf_addr), 64'd0);
        check("abort_dm_rd_en", 64'(dm_rd_en), 64'd0);
        @(posedge clk); #1;
        check("abort_held_valid", 64'(out_valid), 64'd0);
        reset    = 1'b1;
        exp_busy = 1'b0;
        mon_en   = 1'b1;
        run_dump(1'b1, int'($urandom_range(DEPTH - 1)), 2, 100, 1'b0);

        // Random dumps
        for (int t = 0; t < 4; t++) begin
            run_dump(1'($urandom_range(1)), int'($urandom_range(DEPTH - 1)),
                     int'($urandom_range(12)), int'($urandom_range(100, 20)),
                     1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
